// File: rtl/acumulador_rizado_if.sv
// acumulador_rizado_if: operand, flush and result handshake signals of acumulador_rizado
interface acumulador_rizado_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic [3:0] out_ncarry;
   modport master (output in_valid, in_data, flush, out_ready,
                   input  in_ready, out_valid, out_sum, out_ncarry);
   modport slave  (input  in_valid, in_data, flush, out_ready,
                   output in_ready, out_valid, out_sum, out_ncarry);
endinterface

// File: rtl/acumulador_rizado.sv
// acumulador_rizado: sums a burst of N_OPS bytes into an 8-bit total plus a carry-out count
module acumulador_rizado #(
   parameter int PwrC  = 0,
   parameter int N_OPS = 4
) (
   input logic                clk,
   input logic                reset,
   acumulador_rizado_if.slave bus
);
   if (N_OPS < 2 || N_OPS > 16) begin : g_bad_n_ops
      $error("acumulador_rizado: N_OPS=%0d outside 2..16 (PwrC=%0d)", N_OPS, PwrC);
   end
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
   localparam logic [4:0] LAST = 5'(N_OPS);
   state_t     state_q, state_d;
   logic [7:0] acc_q, acc_d;
   logic [4:0] cnt_q, cnt_d;
   logic [3:0] ncarry_q, ncarry_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_sum_q, out_sum_d;
   logic [3:0] out_ncarry_q, out_ncarry_d;
   logic       accept;
   logic [8:0] sum9;
   assign bus.in_ready   = !reset && !bus.flush && state_q != DONE;
   assign accept         = bus.in_valid && bus.in_ready;
   assign sum9           = {1'b0, acc_q} + {1'b0, bus.in_data};
   assign bus.out_valid  = out_valid_q;
   assign bus.out_sum    = out_sum_q;
   assign bus.out_ncarry = out_ncarry_q;
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      ncarry_d     = ncarry_q;
      out_valid_d  = out_valid_q;
      out_sum_d    = out_sum_q;
      out_ncarry_d = out_ncarry_q;
      if (bus.flush) begin
         state_d      = IDLE;
         acc_d        = '0;
         cnt_d        = '0;
         ncarry_d     = '0;
         out_valid_d  = 1'b0;
         out_sum_d    = '0;
         out_ncarry_d = '0;
      end else if (state_q == IDLE && accept) begin
         state_d  = ACC;
         acc_d    = bus.in_data;
         cnt_d    = 5'd1;
         ncarry_d = '0;
      end else if (state_q == ACC && accept) begin
         acc_d    = sum9[7:0];
         cnt_d    = cnt_q + 5'd1;
         ncarry_d = ncarry_q + {3'b000, sum9[8]};
         if (cnt_d == LAST) begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            out_sum_d    = sum9[7:0];
            out_ncarry_d = ncarry_d;
         end
      end else if (state_q == DONE && bus.out_ready) begin
         // result stays on out_sum/out_ncarry; only valid drops
         state_d     = IDLE;
         acc_d       = '0;
         cnt_d       = '0;
         ncarry_d    = '0;
         out_valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         ncarry_q     <= '0;
         out_valid_q  <= 1'b0;
         out_sum_q    <= '0;
         out_ncarry_q <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ncarry_q     <= ncarry_d;
         out_valid_q  <= out_valid_d;
         out_sum_q    <= out_sum_d;
         out_ncarry_q <= out_ncarry_d;
      end
   end
endmodule
